// File: rtl/ram64x8_responder.sv
// 64x8 single-port RAM behind valid/ready command and response ports.
// Optional RAM_INIT_TRACK_EN: per-word written mask; reads of unwritten words flag rsp_err.
`timescale 1ns/1ps

module ram64x8_responder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;

  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                cap_en;
  logic                mem_we;
  logic [DATA_W-1:0]   rd_word;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef RAM_INIT_TRACK_EN
  logic [DEPTH-1:0]    mask_q, mask_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    req_ready = (state_q == IDLE);
    cap_en    = (state_q == IDLE) && req_valid;
    mem_we    = (state_q == ACCESS) && rw_q;

`ifdef RAM_INIT_TRACK_EN
    rd_word = mask_q[addr_q] ? mem[addr_q] : '0;
`else
    rd_word = mem[addr_q];
`endif

    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (cap_en) begin
      rw_d    = req_rw;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end

    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == ACCESS) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = rw_q;
      rsp_rdata_d = rw_q ? '0 : rd_word;
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

`ifdef RAM_INIT_TRACK_EN
    mask_d    = mask_q;
    rsp_err_d = rsp_err_q;
    if (mem_we) begin
      mask_d[addr_q] = 1'b1;
    end
    if (state_q == ACCESS) begin
      rsp_err_d = !rw_q && !mask_q[addr_q];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef RAM_INIT_TRACK_EN
      mask_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_INIT_TRACK_EN
      mask_q      <= mask_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // RAM array is not reset; a reset during ACCESS forces IDLE and so cancels the write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef RAM_INIT_TRACK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram64x8_responder.sv
// Scoreboard bench for ram64x8_responder: directed scenarios plus random traffic
// checked against an array-based memory model.
`timescale 1ns/1ps

module tb_ram64x8_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [5:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  ram64x8_responder #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl_mem [64];
  bit         mdl_wr  [64];
  int         total = 0;
  int         bad   = 0;
  int         rsp_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: memory semantics applied in command-acceptance order
  function automatic exp_t model(input logic rw, input logic [5:0] a, input logic [7:0] d);
    exp_t r;
    if (rw) begin
      mdl_mem[a] = d;
      mdl_wr[a]  = 1'b1;
      r = '{w: 1'b1, d: 8'h00, e: 1'b0};
    end else if (!mdl_wr[a]) begin
      r = '{w: 1'b0, d: 8'h00, e: 1'b1};
    end else begin
      r = '{w: 1'b0, d: mdl_mem[a], e: 1'b0};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rsp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: compare every presented response cycle; pop on handshake
  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 32'(sbq.size()), 32'd1);
      end else begin
        chk("rsp_write", rsp_write, sbq[0].w);
        chk("rsp_rdata", rsp_rdata, sbq[0].d);
        chk("rsp_err",   rsp_err,   sbq[0].e);
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic issue(input logic rw, input logic [5:0] a, input logic [7:0] d, input bit track);
    int n = 0;
    @(posedge clk); #1;
    req_rw = rw; req_addr = a; req_wdata = d; req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(n), 32'd0);
        req_valid = 1'b0;
        return;
      end
    end
    if (track) sbq.push_back(model(rw, a, d));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (track) begin
      chk("lat_access_valid", rsp_valid, 1'b0);
      chk("lat_access_ready", req_ready, 1'b0);
      @(posedge clk); #1;
      chk("lat_rsp_valid", rsp_valid, 1'b1);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_write", rsp_write, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err",   rsp_err,   1'b0);
    sbq.delete();
`ifdef RAM_INIT_TRACK_EN
    foreach (mdl_wr[i]) mdl_wr[i] = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    logic [5:0] a;
    logic       rw;
    int         tries;

    foreach (mdl_wr[i]) mdl_wr[i] = 1'b0;

    // T1: reset state
    repeat (2) @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 8'h00);
    chk("t1_rsp_err",   rsp_err,   1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t1_req_ready", req_ready, 1'b1);
    chk("t1_rsp_valid_post", rsp_valid, 1'b0);

`ifdef RAM_INIT_TRACK_EN
    // T6: unwritten read flags an error
    issue(1'b0, 6'd0, 8'h00, 1'b1);
`endif
    issue(1'b1, 6'd0, 8'd55, 1'b1);
    issue(1'b0, 6'd0, 8'h00, 1'b1);

    // T2 / T3: write then read back
    issue(1'b1, 6'd35, 8'd11, 1'b1);
    issue(1'b0, 6'd35, 8'h00, 1'b1);
    issue(1'b1, 6'd39, 8'd22, 1'b1);
    issue(1'b1, 6'd35, 8'd33, 1'b1);
    issue(1'b0, 6'd39, 8'h00, 1'b1);
    issue(1'b0, 6'd35, 8'h00, 1'b1);
    drain();

    // T4: stalled response holds, extra requests ignored
    @(negedge clk); rsp_mode = 2;
    issue(1'b0, 6'd35, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 6'(i); req_wdata = 8'hA0 + 8'(i);
      chk("t4_req_ready", req_ready, 1'b0);
      chk("t4_rsp_valid", rsp_valid, 1'b1);
    end
    req_valid = 1'b0;
    @(negedge clk); rsp_mode = 0;
    @(posedge clk); #1;
    chk("t4_still_resp", rsp_valid, 1'b1);
    @(posedge clk); #1;
    chk("t4_idle_ready", req_ready, 1'b1);
    chk("t4_idle_valid", rsp_valid, 1'b0);
    drain();

    // T5: reset during ACCESS cancels the write
    issue(1'b1, 6'd35, 8'd44, 1'b0);
    apply_reset();
    issue(1'b0, 6'd35, 8'h00, 1'b1);
    drain();

    // Reset during RESP drops the response at once
    @(negedge clk); rsp_mode = 2;
    issue(1'b0, 6'd39, 8'h00, 1'b1);
    apply_reset();
    rsp_mode = 0;
    chk("rst_resp_ready", req_ready, 1'b1);
    issue(1'b0, 6'd39, 8'h00, 1'b1);
    drain();

    // Random traffic with random back-pressure
    @(negedge clk); rsp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 6'($urandom);
`ifndef RAM_INIT_TRACK_EN
      tries = 0;
      while (!rw && !mdl_wr[a] && tries < 1000) begin
        a = 6'($urandom);
        tries++;
      end
      if (!mdl_wr[a]) rw = 1'b1;
`endif
      issue(rw, a, 8'($urandom), 1'b1);
    end
    @(negedge clk); rsp_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
